// File: rtl/axi_user_arbiter.sv
// Two-port transaction arbiter in front of axi_rw: instruction fetch (read-only) and data (read/write)
// share one user request port; one whole transaction is owned by the winner until its ready pulse.
module axi_user_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 512,
   parameter bit RR_EN  = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   input  logic [1:0]        if_size_i,
   input  logic [7:0]        if_blks_i,
   output logic              if_ready_o,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic [1:0]        if_resp_o,
   input  logic              mem_valid_i,
   input  logic              mem_op_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   input  logic [1:0]        mem_size_i,
   input  logic [7:0]        mem_blks_i,
   output logic              mem_ready_o,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic [1:0]        mem_resp_o,
   output logic              axi_valid_o,
   output logic              axi_op_o,
   output logic [ADDR_W-1:0] axi_addr_o,
   output logic [DATA_W-1:0] axi_wdata_o,
   output logic [1:0]        axi_size_o,
   output logic [7:0]        axi_blks_o,
   input  logic              axi_ready_i,
   input  logic [DATA_W-1:0] axi_rdata_i,
   input  logic [1:0]        axi_resp_i,
   output logic [1:0]        grant_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state_r;
   logic                last_mem_r;
   logic                pick_mem_s;
   logic                if_ready_r;
   logic                mem_ready_r;
   logic [DATA_W-1:0]   rdata_r;
   logic [1:0]          resp_r;
   logic                axi_valid_r;
   logic                axi_op_r;
   logic [ADDR_W-1:0]   axi_addr_r;
   logic [DATA_W-1:0]   axi_wdata_r;
   logic [1:0]          axi_size_r;
   logic [7:0]          axi_blks_r;
   logic [1:0]          grant_r;

   // Winner selection; on a tie round-robin favours the port not served last.
   always_comb begin
      pick_mem_s = 1'b0;
      if (mem_valid_i && !if_valid_i) begin
         pick_mem_s = 1'b1;
      end else if (mem_valid_i && if_valid_i) begin
         pick_mem_s = RR_EN ? !last_mem_r : 1'b1;
      end else begin
         pick_mem_s = 1'b0;
      end
   end

   // Transaction FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= IDLE;
         last_mem_r  <= 1'b1;
         if_ready_r  <= 1'b0;
         mem_ready_r <= 1'b0;
         rdata_r     <= '0;
         resp_r      <= 2'b00;
         axi_valid_r <= 1'b0;
         axi_op_r    <= 1'b0;
         axi_addr_r  <= '0;
         axi_wdata_r <= '0;
         axi_size_r  <= 2'b00;
         axi_blks_r  <= 8'h00;
         grant_r     <= 2'b00;
      end else begin
         case (state_r)
            IDLE: begin
               if (if_valid_i || mem_valid_i) begin
                  state_r     <= BUSY;
                  axi_valid_r <= 1'b1;
                  if (pick_mem_s) begin
                     axi_op_r    <= mem_op_i;
                     axi_addr_r  <= mem_addr_i;
                     axi_wdata_r <= mem_wdata_i;
                     axi_size_r  <= mem_size_i;
                     axi_blks_r  <= mem_blks_i;
                     grant_r     <= 2'b10;
                  end else begin
                     axi_op_r    <= 1'b0;
                     axi_addr_r  <= if_addr_i;
                     axi_wdata_r <= '0;
                     axi_size_r  <= if_size_i;
                     axi_blks_r  <= if_blks_i;
                     grant_r     <= 2'b01;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            BUSY: begin
               if (axi_ready_i) begin
                  state_r     <= RESP;
                  axi_valid_r <= 1'b0;
                  rdata_r     <= axi_rdata_i;
                  resp_r      <= axi_resp_i;
                  if_ready_r  <= grant_r[0];
                  mem_ready_r <= grant_r[1];
               end else begin
                  state_r <= BUSY;
               end
            end
            RESP: begin
               // Requesters may still hold valid this cycle; IDLE samples them only afterwards.
               state_r     <= IDLE;
               if_ready_r  <= 1'b0;
               mem_ready_r <= 1'b0;
               last_mem_r  <= grant_r[1];
               grant_r     <= 2'b00;
            end
            default: begin
               state_r     <= IDLE;
               if_ready_r  <= 1'b0;
               mem_ready_r <= 1'b0;
               axi_valid_r <= 1'b0;
               grant_r     <= 2'b00;
            end
         endcase
      end
   end

   assign if_ready_o  = if_ready_r;
   assign mem_ready_o = mem_ready_r;
   assign if_rdata_o  = rdata_r;
   assign mem_rdata_o = rdata_r;
   assign if_resp_o   = resp_r;
   assign mem_resp_o  = resp_r;
   assign axi_valid_o = axi_valid_r;
   assign axi_op_o    = axi_op_r;
   assign axi_addr_o  = axi_addr_r;
   assign axi_wdata_o = axi_wdata_r;
   assign axi_size_o  = axi_size_r;
   assign axi_blks_o  = axi_blks_r;
   assign grant_o     = grant_r;

endmodule

// File: tb/tb_axi_user_arbiter.sv
// Directed bench for axi_user_arbiter: a round-robin and a fixed-priority instance share one stimulus set.
module tb_axi_user_arbiter;
   localparam int AW = 64;
   localparam int DW = 512;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          if_valid, mem_valid, mem_op, axi_ready;
   logic [AW-1:0] if_addr, mem_addr;
   logic [1:0]    if_size, mem_size, axi_resp;
   logic [7:0]    if_blks, mem_blks;
   logic [DW-1:0] mem_wdata, axi_rdata;

   logic          if_ready_rr, mem_ready_rr, axi_valid_rr, axi_op_rr;
   logic [DW-1:0] if_rdata_rr, mem_rdata_rr, axi_wdata_rr;
   logic [1:0]    if_resp_rr, mem_resp_rr, axi_size_rr, grant_rr;
   logic [AW-1:0] axi_addr_rr;
   logic [7:0]    axi_blks_rr;

   logic          if_ready_fp, mem_ready_fp, axi_valid_fp, axi_op_fp;
   logic [DW-1:0] if_rdata_fp, mem_rdata_fp, axi_wdata_fp;
   logic [1:0]    if_resp_fp, mem_resp_fp, axi_size_fp, grant_fp;
   logic [AW-1:0] axi_addr_fp;
   logic [7:0]    axi_blks_fp;

   axi_user_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .if_valid_i(if_valid), .if_addr_i(if_addr), .if_size_i(if_size), .if_blks_i(if_blks),
      .if_ready_o(if_ready_rr), .if_rdata_o(if_rdata_rr), .if_resp_o(if_resp_rr),
      .mem_valid_i(mem_valid), .mem_op_i(mem_op), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
      .mem_size_i(mem_size), .mem_blks_i(mem_blks),
      .mem_ready_o(mem_ready_rr), .mem_rdata_o(mem_rdata_rr), .mem_resp_o(mem_resp_rr),
      .axi_valid_o(axi_valid_rr), .axi_op_o(axi_op_rr), .axi_addr_o(axi_addr_rr),
      .axi_wdata_o(axi_wdata_rr), .axi_size_o(axi_size_rr), .axi_blks_o(axi_blks_rr),
      .axi_ready_i(axi_ready), .axi_rdata_i(axi_rdata), .axi_resp_i(axi_resp),
      .grant_o(grant_rr)
   );

   axi_user_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b0)) dut_fp (
      .clk(clk), .rst(rst),
      .if_valid_i(if_valid), .if_addr_i(if_addr), .if_size_i(if_size), .if_blks_i(if_blks),
      .if_ready_o(if_ready_fp), .if_rdata_o(if_rdata_fp), .if_resp_o(if_resp_fp),
      .mem_valid_i(mem_valid), .mem_op_i(mem_op), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
      .mem_size_i(mem_size), .mem_blks_i(mem_blks),
      .mem_ready_o(mem_ready_fp), .mem_rdata_o(mem_rdata_fp), .mem_resp_o(mem_resp_fp),
      .axi_valid_o(axi_valid_fp), .axi_op_o(axi_op_fp), .axi_addr_o(axi_addr_fp),
      .axi_wdata_o(axi_wdata_fp), .axi_size_o(axi_size_fp), .axi_blks_o(axi_blks_fp),
      .axi_ready_i(axi_ready), .axi_rdata_i(axi_rdata), .axi_resp_i(axi_resp),
      .grant_o(grant_fp)
   );

   typedef struct packed {
      logic       rst;
      logic       ifv;
      logic       memv;
      logic       axr;
      logic [1:0] grant;
      logic       axv;
      logic       ifr;
      logic       memr;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [DW-1:0] pat_a, pat_w;
      // rst ifv memv axr | grant axv ifr memr   (expected after the edge)
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1};
      vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
      vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};

      pat_a = {16{32'hA5A5_0001}};
      pat_w = {64{8'h5A}};

      rst = 1'b0; if_valid = 1'b0; mem_valid = 1'b0; mem_op = 1'b0; axi_ready = 1'b0;
      if_addr = 64'h0000_0000_8000_0000; if_size = 2'd3; if_blks = 8'd7;
      mem_addr = 64'h0000_0000_0000_1000; mem_size = 2'd2; mem_blks = 8'd0;
      mem_wdata = '0; axi_rdata = {16{32'h1234_5678}}; axi_resp = 2'b00;

      // Cycle-level grant/handshake table on the round-robin instance.
      for (int i = 0; i < NV; i++) begin
         rst = vecs[i].rst; if_valid = vecs[i].ifv; mem_valid = vecs[i].memv; axi_ready = vecs[i].axr;
         step();
         chk($sformatf("v%0d grant", i), DW'(grant_rr), DW'(vecs[i].grant));
         chk($sformatf("v%0d axi_valid", i), DW'(axi_valid_rr), DW'(vecs[i].axv));
         chk($sformatf("v%0d if_ready", i), DW'(if_ready_rr), DW'(vecs[i].ifr));
         chk($sformatf("v%0d mem_ready", i), DW'(mem_ready_rr), DW'(vecs[i].memr));
      end

      // IF read of 8 beats: request fields forwarded, read data returned one cycle after axi_ready.
      if_valid = 1'b1; axi_ready = 1'b0;
      step();
      chk("if grant", DW'(grant_rr), DW'(2'b01));
      chk("if axi_addr", DW'(axi_addr_rr), DW'(64'h0000_0000_8000_0000));
      chk("if axi_blks", DW'(axi_blks_rr), DW'(8'd7));
      chk("if axi_size", DW'(axi_size_rr), DW'(2'd3));
      chk("if axi_op", DW'(axi_op_rr), DW'(1'b0));
      chk("if axi_wdata", axi_wdata_rr, {DW{1'b0}});
      step();
      chk("if busy hold", DW'(axi_valid_rr), DW'(1'b1));
      axi_rdata = pat_a; axi_resp = 2'b00; axi_ready = 1'b1;
      step();
      chk("if ready", DW'(if_ready_rr), DW'(1'b1));
      chk("if rdata", if_rdata_rr, pat_a);
      chk("if resp", DW'(if_resp_rr), DW'(2'b00));
      chk("if no mem_ready", DW'(mem_ready_rr), DW'(1'b0));
      axi_ready = 1'b0;
      step();
      chk("if ready one cycle", DW'(if_ready_rr), DW'(1'b0));
      if_valid = 1'b0;
      step();

      // MEM write: op and write data forwarded, error response returned.
      mem_valid = 1'b1; mem_op = 1'b1; mem_wdata = pat_w; mem_addr = 64'h0000_0000_0000_2000;
      step();
      chk("wr grant", DW'(grant_rr), DW'(2'b10));
      chk("wr axi_op", DW'(axi_op_rr), DW'(1'b1));
      chk("wr axi_wdata", axi_wdata_rr, pat_w);
      chk("wr axi_addr", DW'(axi_addr_rr), DW'(64'h0000_0000_0000_2000));
      axi_resp = 2'b10; axi_ready = 1'b1;
      step();
      chk("wr mem_ready", DW'(mem_ready_rr), DW'(1'b1));
      chk("wr mem_resp", DW'(mem_resp_rr), DW'(2'b10));
      chk("wr no if_ready", DW'(if_ready_rr), DW'(1'b0));
      axi_ready = 1'b0;
      step();
      mem_valid = 1'b0; mem_op = 1'b0; axi_resp = 2'b00;
      step();

      // Fixed priority: with both valid held, MEM wins every round; IF only once MEM drops.
      rst = 1'b0;
      step();
      rst = 1'b1; if_valid = 1'b1; mem_valid = 1'b1;
      for (int r = 0; r < 3; r++) begin
         step();
         chk($sformatf("fp r%0d grant", r), DW'(grant_fp), DW'(2'b10));
         axi_ready = 1'b1;
         step();
         chk($sformatf("fp r%0d mem_ready", r), DW'(mem_ready_fp), DW'(1'b1));
         axi_ready = 1'b0;
         step();
         if (r == 2) mem_valid = 1'b0;
      end
      step();
      chk("fp if served", DW'(grant_fp), DW'(2'b01));
      if_valid = 1'b0;
      step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
